sdram_write_bst: RTL and testbench

Parametrised SDRAM burst-write engine for the controller's write channel. It is the next-generation write block.
- Accepts one write request of arbitrary length (0 to 2^LEN_W-1 words).
- Splits a request that crosses a column-page boundary into several ACT/WR/BST/PRE segments.
- Enforces tWR as well as tRCD/tRP.
- Outputs feed the existing command arbiter through the wr_sdram_* bus.

---
 rtl/sdram_pkg.sv | 27 ++
 rtl/sdram_page_split.sv | 40 ++++
 rtl/sdram_write_bst.sv | 244 ++++++++++++++++++++++++
 tb/tb_sdram_write_bst.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions for the write, read and refresh blocks.
// Contents: SDRAM command codes {CS#,RAS#,CAS#,WE#}, the engine state
// enum, and the fill pattern for idle bank/address values.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_BST = 4'b0110;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  // Idle bank/address values are all ones; users cast this to their width.
  localparam logic [31:0] IDLE_FILL = '1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ACT,
    S_TRCD,
    S_DATA,
    S_BST,
    S_TWR,
    S_PRE,
    S_TRP,
    S_END
  } state_t;

endpackage

// File: rtl/sdram_page_split.sv
// Column-page split helper (purely combinational).
// i_cur_col/i_rem  : current column and words still to write
// i_cur_bank/row   : current bank and row
// o_seg            : beats in this segment = min(rem, 2^COL_W - col)
// o_next_bank/row  : {bank,row} + 1; the carry runs from row into bank and
//                    the top address wraps to zero
module sdram_page_split #(
  parameter int unsigned BANK_W = 2,
  parameter int unsigned ROW_W  = 13,
  parameter int unsigned COL_W  = 9,
  parameter int unsigned LEN_W  = 10
) (
  input  logic [COL_W-1:0]  i_cur_col,
  input  logic [LEN_W-1:0]  i_rem,
  input  logic [BANK_W-1:0] i_cur_bank,
  input  logic [ROW_W-1:0]  i_cur_row,
  output logic [COL_W:0]    o_seg,
  output logic [BANK_W-1:0] o_next_bank,
  output logic [ROW_W-1:0]  o_next_row
);

  localparam int unsigned CW   = (LEN_W > COL_W + 1) ? LEN_W : COL_W + 1;
  localparam int unsigned BR_W = BANK_W + ROW_W;

  logic [CW-1:0]   w_room;
  logic [CW-1:0]   w_rem;
  logic [CW-1:0]   w_seg;
  logic [BR_W-1:0] w_next_br;

  // Words left before the column counter would leave the page.
  assign w_room = CW'(2 ** COL_W) - CW'(i_cur_col);
  assign w_rem  = CW'(i_rem);
  // min() never exceeds 2^COL_W, so COL_W+1 bits always hold it.
  assign w_seg  = (w_rem < w_room) ? w_rem : w_room;
  assign o_seg  = (COL_W + 1)'(w_seg);

  assign w_next_br                 = {i_cur_bank, i_cur_row} + BR_W'(1);
  assign {o_next_bank, o_next_row} = w_next_br;

endmodule

// File: rtl/sdram_write_bst.sv
// SDRAM burst-write engine for the controller's write channel.
// Takes one request of 0..2^LEN_W-1 words and issues ACT/WR/BST/PRE
// segments, splitting at column-page ends and honouring tRCD, tWR and tRP.
// wr_clk/wr_rst      : clock, asynchronous active-high reset
// init_end           : SDRAM initialisation finished
// wr_en/wr_addr/len  : request (level), start {bank,row,col}, word count
// wr_data/wr_ack     : show-ahead FIFO word and its pop strobe
// wr_busy/wr_end     : request in progress, one-cycle completion pulse
// wr_sdram_*         : command/bank/address/data towards the arbiter
module sdram_write_bst
  import sdram_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned BANK_W = 2,
  parameter int unsigned ROW_W  = 13,
  parameter int unsigned COL_W  = 9,
  parameter int unsigned LEN_W  = 10,
  parameter int unsigned TRCD   = 2,
  parameter int unsigned TWR    = 2,
  parameter int unsigned TRP    = 2
) (
  input  logic                            wr_clk,
  input  logic                            wr_rst,
  input  logic                            init_end,
  input  logic                            wr_en,
  input  logic [BANK_W+ROW_W+COL_W-1:0]   wr_addr,
  input  logic [LEN_W-1:0]                wr_bst_len,
  input  logic [DATA_W-1:0]               wr_data,
  output logic                            wr_ack,
  output logic                            wr_busy,
  output logic                            wr_end,
  output logic [3:0]                      wr_sdram_cmd,
  output logic [BANK_W-1:0]               wr_sdram_bank,
  output logic [ROW_W-1:0]                wr_sdram_addr,
  output logic                            wr_sdram_en,
  output logic [DATA_W-1:0]               wr_sdram_data
);

  localparam int unsigned ADDR_W = BANK_W + ROW_W + COL_W;
  localparam int unsigned SEG_W  = COL_W + 1;
  localparam int unsigned WAIT_W = 8;

  localparam logic [BANK_W-1:0] IDLE_BANK = BANK_W'(IDLE_FILL);
  localparam logic [ROW_W-1:0]  IDLE_ADDR = ROW_W'(IDLE_FILL);

  state_t              r_state;
  logic [BANK_W-1:0]   r_cur_bank;
  logic [ROW_W-1:0]    r_cur_row;
  logic [COL_W-1:0]    r_cur_col;
  logic [LEN_W-1:0]    r_rem;
  logic [SEG_W-1:0]    r_cnt;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_first;
  logic                r_ack;
  logic                r_busy;
  logic                r_end;

  logic [3:0]          r_cmd;
  logic [BANK_W-1:0]   r_bank;
  logic [ROW_W-1:0]    r_addr;
  logic                r_sdram_en;
  logic [DATA_W-1:0]   r_sdram_data;

  logic [SEG_W-1:0]    w_seg;
  logic [BANK_W-1:0]   w_next_bank;
  logic [ROW_W-1:0]    w_next_row;
  logic                w_pre_done;

  sdram_page_split #(
    .BANK_W (BANK_W),
    .ROW_W  (ROW_W),
    .COL_W  (COL_W),
    .LEN_W  (LEN_W)
  ) u_page_split (
    .i_cur_col   (r_cur_col),
    .i_rem       (r_rem),
    .i_cur_bank  (r_cur_bank),
    .i_cur_row   (r_cur_row),
    .o_seg       (w_seg),
    .o_next_bank (w_next_bank),
    .o_next_row  (w_next_row)
  );

  // Precharge spacing has elapsed (PRE itself when TRP=1).
  assign w_pre_done = ((r_state == S_PRE) && (TRP == 1)) ||
                      ((r_state == S_TRP) && (r_wait == '0));

  // Sequencer: state, request context, ack/busy/end strobes.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      r_state    <= S_IDLE;
      r_cur_bank <= '0;
      r_cur_row  <= '0;
      r_cur_col  <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_wait     <= '0;
      r_first    <= 1'b0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_end      <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_end <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (wr_en && init_end) begin
            r_cur_bank <= wr_addr[ADDR_W-1 -: BANK_W];
            r_cur_row  <= wr_addr[COL_W +: ROW_W];
            r_cur_col  <= wr_addr[COL_W-1:0];
            r_rem      <= wr_bst_len;
            r_busy     <= 1'b1;
            if (wr_bst_len == '0) begin
              r_state <= S_END;
              r_end   <= 1'b1;
            end else begin
              r_state <= S_ACT;
            end
          end
        end
        S_ACT: begin
          r_cnt <= w_seg;
          if (TRCD == 1) begin
            r_state <= S_DATA;
            r_ack   <= 1'b1;
            r_first <= 1'b1;
          end else begin
            r_state <= S_TRCD;
            r_wait  <= WAIT_W'(TRCD - 2);
          end
        end
        S_TRCD: begin
          if (r_wait == '0) begin
            r_state <= S_DATA;
            r_ack   <= 1'b1;
            r_first <= 1'b1;
          end else begin
            r_wait <= r_wait - WAIT_W'(1);
          end
        end
        S_DATA: begin
          // One word leaves the FIFO in every DATA cycle.
          r_rem   <= r_rem - LEN_W'(1);
          r_first <= 1'b0;
          if (r_cnt == SEG_W'(1)) begin
            r_state <= S_BST;
          end else begin
            r_cnt <= r_cnt - SEG_W'(1);
            r_ack <= 1'b1;
          end
        end
        S_BST: begin
          if (TWR == 1) begin
            r_state <= S_PRE;
          end else begin
            r_state <= S_TWR;
            r_wait  <= WAIT_W'(TWR - 2);
          end
        end
        S_TWR: begin
          if (r_wait == '0) r_state <= S_PRE;
          else              r_wait  <= r_wait - WAIT_W'(1);
        end
        S_PRE, S_TRP: begin
          if (w_pre_done) begin
            if (r_rem == '0) begin
              r_state <= S_END;
              r_end   <= 1'b1;
            end else begin
              // Continue at the start of the next page.
              r_state    <= S_ACT;
              r_cur_col  <= '0;
              r_cur_bank <= w_next_bank;
              r_cur_row  <= w_next_row;
            end
          end else if (r_state == S_PRE) begin
            r_state <= S_TRP;
            r_wait  <= WAIT_W'(TRP - 2);
          end else begin
            r_wait <= r_wait - WAIT_W'(1);
          end
        end
        S_END: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Command bus lags the state by one cycle; data lags wr_ack by one cycle,
  // which lines each word up with its WR/NOP slot.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      r_cmd        <= CMD_NOP;
      r_bank       <= IDLE_BANK;
      r_addr       <= IDLE_ADDR;
      r_sdram_en   <= 1'b0;
      r_sdram_data <= '0;
    end else begin
      r_cmd  <= CMD_NOP;
      r_bank <= IDLE_BANK;
      r_addr <= IDLE_ADDR;
      case (r_state)
        S_ACT: begin
          r_cmd  <= CMD_ACT;
          r_bank <= r_cur_bank;
          r_addr <= r_cur_row;
        end
        S_DATA: begin
          if (r_first) begin
            // COL_W <= 10, so zero-extension leaves A10 (auto-precharge) low.
            r_cmd  <= CMD_WR;
            r_bank <= r_cur_bank;
            r_addr <= ROW_W'(r_cur_col);
          end
        end
        S_BST: r_cmd <= CMD_BST;
        S_PRE: begin
          r_cmd  <= CMD_PRE;
          r_bank <= r_cur_bank;
          r_addr <= '0;
        end
        default: ;
      endcase
      r_sdram_en   <= r_ack;
      r_sdram_data <= r_ack ? wr_data : '0;
    end
  end

  assign wr_ack        = r_ack;
  assign wr_busy       = r_busy;
  assign wr_end        = r_end;
  assign wr_sdram_cmd  = r_cmd;
  assign wr_sdram_bank = r_bank;
  assign wr_sdram_addr = r_addr;
  assign wr_sdram_en   = r_sdram_en;
  assign wr_sdram_data = r_sdram_data;

endmodule

// File: tb/tb_sdram_write_bst.sv
// Directed self-checking bench for sdram_write_bst (default parameters).
module tb_sdram_write_bst;
  import sdram_pkg::*;

  logic        wr_clk;
  logic        wr_rst;
  logic        init_end;
  logic        wr_en;
  logic [23:0] wr_addr;
  logic [9:0]  wr_bst_len;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        wr_busy;
  logic        wr_end;
  logic [3:0]  wr_sdram_cmd;
  logic [1:0]  wr_sdram_bank;
  logic [12:0] wr_sdram_addr;
  logic        wr_sdram_en;
  logic [15:0] wr_sdram_data;

  int n_chk = 0;
  int n_err = 0;

  // Show-ahead FIFO model: the word at the head is popped by each wr_ack.
  logic [15:0] fifo_mem [16];
  int ack_total = 0;
  int fifo_base = 0;
  assign wr_data = fifo_mem[4'(ack_total - fifo_base)];
  always @(posedge wr_clk) if (wr_ack) ack_total <= ack_total + 1;

  // Per-cycle bus record of the last capture window.
  logic [3:0]  q_cmd [$];
  logic [1:0]  q_bank [$];
  logic [12:0] q_addr [$];
  logic        q_en [$];
  logic [15:0] q_data [$];
  logic        q_ack [$];
  logic        q_busy [$];
  logic        q_end [$];
  // Non-NOP commands and driven data words of that window.
  logic [3:0]  nc_cmd [$];
  logic [1:0]  nc_bank [$];
  logic [12:0] nc_addr [$];
  logic [15:0] dq [$];
  int n_ack_c, n_end_c, n_busy_c, first_idx;

  sdram_write_bst dut (
    .wr_clk        (wr_clk),
    .wr_rst        (wr_rst),
    .init_end      (init_end),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_bst_len    (wr_bst_len),
    .wr_data       (wr_data),
    .wr_ack        (wr_ack),
    .wr_busy       (wr_busy),
    .wr_end        (wr_end),
    .wr_sdram_cmd  (wr_sdram_cmd),
    .wr_sdram_bank (wr_sdram_bank),
    .wr_sdram_addr (wr_sdram_addr),
    .wr_sdram_en   (wr_sdram_en),
    .wr_sdram_data (wr_sdram_data)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  task automatic start_req(input logic [1:0] b, input logic [12:0] r, input logic [8:0] c,
                           input logic [9:0] len, input logic [15:0] base);
    @(negedge wr_clk);
    fifo_base = ack_total;
    for (int i = 0; i < 16; i++) fifo_mem[i] = base + 16'(i);
    wr_addr    = {b, r, c};
    wr_bst_len = len;
    wr_en      = 1'b1;
  endtask

  // Records the bus every cycle until two cycles after wr_end; wr_en drops
  // after the first cycle and optionally re-rises at raise_at for two cycles.
  task automatic capture(input int raise_at, input logic [23:0] alt_addr);
    bit seen;
    int tail;
    q_cmd.delete(); q_bank.delete(); q_addr.delete(); q_en.delete();
    q_data.delete(); q_ack.delete(); q_busy.delete(); q_end.delete();
    seen = 0;
    tail = 0;
    for (int i = 0; i < 200 && tail < 3; i++) begin
      @(negedge wr_clk);
      q_cmd.push_back(wr_sdram_cmd);  q_bank.push_back(wr_sdram_bank);
      q_addr.push_back(wr_sdram_addr); q_en.push_back(wr_sdram_en);
      q_data.push_back(wr_sdram_data); q_ack.push_back(wr_ack);
      q_busy.push_back(wr_busy);       q_end.push_back(wr_end);
      if (wr_end) seen = 1;
      if (seen) tail++;
      if (i == 0) wr_en = 1'b0;
      if (i == raise_at) begin wr_en = 1'b1; wr_addr = alt_addr; end
      if (i == raise_at + 2) wr_en = 1'b0;
    end
    n_chk++;
    if (!seen) begin
      n_err++;
      $display("FAIL capture_timeout: wr_end seen=%0d required=1", seen);
    end
    nc_cmd.delete(); nc_bank.delete(); nc_addr.delete(); dq.delete();
    n_ack_c = 0; n_end_c = 0; n_busy_c = 0; first_idx = -1;
    for (int k = 0; k < q_cmd.size(); k++) begin
      if (q_cmd[k] != CMD_NOP) begin
        if (first_idx < 0) first_idx = k;
        nc_cmd.push_back(q_cmd[k]); nc_bank.push_back(q_bank[k]); nc_addr.push_back(q_addr[k]);
      end
      if (q_en[k]) dq.push_back(q_data[k]);
      n_ack_c  += int'(q_ack[k]);
      n_end_c  += int'(q_end[k]);
      n_busy_c += int'(q_busy[k]);
    end
  endtask

  task automatic test_reset();
    wr_rst = 1'b1; init_end = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_bst_len = '0;
    for (int i = 0; i < 16; i++) fifo_mem[i] = '0;
    repeat (2) @(negedge wr_clk);
    n_chk++;
    if (wr_sdram_cmd !== CMD_NOP || wr_sdram_bank !== 2'h3 || wr_sdram_addr !== 13'h1FFF) begin
      n_err++;
      $display("FAIL reset_bus: cmd=%b bank=%h addr=%h required 0111/3/1fff",
               wr_sdram_cmd, wr_sdram_bank, wr_sdram_addr);
    end
    n_chk++;
    if (wr_sdram_en !== 1'b0 || wr_sdram_data !== 16'h0) begin
      n_err++;
      $display("FAIL reset_data: en=%b data=%h required 0/0000", wr_sdram_en, wr_sdram_data);
    end
    n_chk++;
    if (wr_ack !== 1'b0 || wr_busy !== 1'b0 || wr_end !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: ack=%b busy=%b end=%b required 0/0/0", wr_ack, wr_busy, wr_end);
    end
    wr_rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0]  e_cmd  [10];
    logic [1:0]  e_bank [10];
    logic [12:0] e_addr [10];
    logic        e_en   [10];
    logic [15:0] e_data [10];
    logic        e_ba   [10];
    int j;
    e_cmd  = '{CMD_ACT, CMD_NOP, CMD_WR, CMD_NOP, CMD_NOP, CMD_NOP, CMD_BST, CMD_NOP, CMD_PRE, CMD_NOP};
    e_bank = '{2'h1, 2'h3, 2'h1, 2'h3, 2'h3, 2'h3, 2'h3, 2'h3, 2'h1, 2'h3};
    e_addr = '{13'h0123, 13'h1FFF, 13'h0010, 13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1FFF,
               13'h0000, 13'h1FFF};
    e_en   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    e_data = '{16'h0, 16'h0, 16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3, 16'h0, 16'h0, 16'h0, 16'h0};
    e_ba   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    start_req(2'h1, 13'h0123, 9'h010, 10'd4, 16'h00A0);
    capture(-1, '0);
    // ACT shows up on the bus two cycles after the request is presented.
    n_chk++;
    if (first_idx !== 1) begin
      n_err++;
      $display("FAIL basic_act_latency: first command at sample %0d required 1", first_idx);
    end
    for (int k = 0; k < 10; k++) begin
      j = 1 + k;
      n_chk++;
      if (j >= q_cmd.size()) begin
        n_err++;
        $display("FAIL basic_seq[%0d]: record too short (%0d) required > %0d", k, q_cmd.size(), j);
      end else if (q_cmd[j] !== e_cmd[k] || q_en[j] !== e_en[k] || q_data[j] !== e_data[k] ||
                   (e_ba[k] && (q_bank[j] !== e_bank[k] || q_addr[j] !== e_addr[k]))) begin
        n_err++;
        $display("FAIL basic_seq[%0d]: cmd=%b bank=%h addr=%h en=%b data=%h required %b/%h/%h/%b/%h",
                 k, q_cmd[j], q_bank[j], q_addr[j], q_en[j], q_data[j],
                 e_cmd[k], e_bank[k], e_addr[k], e_en[k], e_data[k]);
      end
    end
    n_chk++;
    if (q_end.size() < 12 || q_end[10] !== 1'b1 || q_busy[11] !== 1'b0) begin
      n_err++;
      $display("FAIL basic_end_timing: end@10=%b busy@11=%b required 1/0",
               (q_end.size() > 10) ? q_end[10] : 1'bx, (q_busy.size() > 11) ? q_busy[11] : 1'bx);
    end
    n_chk++;
    if (n_ack_c != 4 || n_end_c != 1) begin
      n_err++;
      $display("FAIL basic_counts: acks=%0d ends=%0d required 4/1", n_ack_c, n_end_c);
    end
  endtask

  task automatic test_page_split();
    logic [3:0]  e_cmd  [8];
    logic [1:0]  e_bank [8];
    logic [12:0] e_addr [8];
    e_cmd  = '{CMD_ACT, CMD_WR, CMD_BST, CMD_PRE, CMD_ACT, CMD_WR, CMD_BST, CMD_PRE};
    e_bank = '{2'h2, 2'h2, 2'h0, 2'h2, 2'h2, 2'h2, 2'h0, 2'h2};
    e_addr = '{13'h0040, 13'h01FE, 13'h0, 13'h0000, 13'h0041, 13'h0000, 13'h0, 13'h0000};
    start_req(2'h2, 13'h0040, 9'h1FE, 10'd5, 16'h00B0);
    capture(-1, '0);
    n_chk++;
    if (nc_cmd.size() != 8) begin
      n_err++;
      $display("FAIL split_cmd_count: %0d commands required 8", nc_cmd.size());
    end
    for (int k = 0; k < 8 && k < nc_cmd.size(); k++) begin
      n_chk++;
      if (nc_cmd[k] !== e_cmd[k] ||
          (e_cmd[k] != CMD_BST && (nc_bank[k] !== e_bank[k] || nc_addr[k] !== e_addr[k]))) begin
        n_err++;
        $display("FAIL split_cmd[%0d]: cmd=%b bank=%h addr=%h required %b/%h/%h",
                 k, nc_cmd[k], nc_bank[k], nc_addr[k], e_cmd[k], e_bank[k], e_addr[k]);
      end
    end
    n_chk++;
    if (dq.size() != 5) begin
      n_err++;
      $display("FAIL split_words: %0d words required 5", dq.size());
    end
    for (int k = 0; k < 5 && k < dq.size(); k++) begin
      n_chk++;
      if (dq[k] !== 16'h00B0 + 16'(k)) begin
        n_err++;
        $display("FAIL split_data[%0d]: %h required %h", k, dq[k], 16'h00B0 + 16'(k));
      end
    end
    n_chk++;
    if (n_ack_c != 5 || n_end_c != 1) begin
      n_err++;
      $display("FAIL split_counts: acks=%0d ends=%0d required 5/1", n_ack_c, n_end_c);
    end
  endtask

  task automatic test_carry();
    logic [1:0]  s_bank [2];
    logic [1:0]  e_bank [2];
    logic [12:0] e_row  [2];
    s_bank = '{2'h0, 2'h3};
    e_bank = '{2'h1, 2'h0};
    e_row  = '{13'h0000, 13'h0000};
    for (int t = 0; t < 2; t++) begin
      start_req(s_bank[t], 13'h1FFF, 9'h1FF, 10'd2, 16'h00D0);
      capture(-1, '0);
      n_chk++;
      if (nc_cmd.size() != 8 || nc_cmd[0] !== CMD_ACT || nc_bank[0] !== s_bank[t] ||
          nc_addr[0] !== 13'h1FFF || nc_cmd[1] !== CMD_WR || nc_addr[1] !== 13'h01FF) begin
        n_err++;
        $display("FAIL carry%0d_first_seg: ncmds=%0d act=%b/%h/%h required 8 ACT/%h/1fff",
                 t, nc_cmd.size(), nc_cmd[0], nc_bank[0], nc_addr[0], s_bank[t]);
      end
      n_chk++;
      if (nc_cmd.size() < 6 || nc_cmd[4] !== CMD_ACT || nc_bank[4] !== e_bank[t] ||
          nc_addr[4] !== e_row[t] || nc_cmd[5] !== CMD_WR || nc_addr[5] !== 13'h0000) begin
        n_err++;
        $display("FAIL carry%0d_second_act: ncmds=%0d act=%b bank=%h row=%h required ACT/%h/%h",
                 t, nc_cmd.size(), (nc_cmd.size() > 4) ? nc_cmd[4] : 4'hx,
                 (nc_bank.size() > 4) ? nc_bank[4] : 2'hx,
                 (nc_addr.size() > 4) ? nc_addr[4] : 13'hx, e_bank[t], e_row[t]);
      end
      n_chk++;
      if (n_ack_c != 2 || n_end_c != 1) begin
        n_err++;
        $display("FAIL carry%0d_counts: acks=%0d ends=%0d required 2/1", t, n_ack_c, n_end_c);
      end
    end
  endtask

  task automatic test_len0();
    start_req(2'h1, 13'h0123, 9'h010, 10'd0, 16'h00E0);
    capture(-1, '0);
    n_chk++;
    if (nc_cmd.size() != 0 || n_ack_c != 0) begin
      n_err++;
      $display("FAIL len0_quiet: commands=%0d acks=%0d required 0/0", nc_cmd.size(), n_ack_c);
    end
    n_chk++;
    if (n_end_c != 1 || n_busy_c != 1) begin
      n_err++;
      $display("FAIL len0_end_busy: ends=%0d busy_cycles=%0d required 1/1", n_end_c, n_busy_c);
    end
  endtask

  task automatic test_gating();
    int act;
    @(negedge wr_clk);
    init_end = 1'b0; wr_en = 1'b1; wr_addr = {2'h1, 13'h0123, 9'h010}; wr_bst_len = 10'd4;
    act = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge wr_clk);
      if (wr_busy || wr_ack || wr_end || wr_sdram_cmd != CMD_NOP) act++;
    end
    wr_en = 1'b0;
    init_end = 1'b1;
    n_chk++;
    if (act != 0) begin
      n_err++;
      $display("FAIL gate_init_end: %0d active cycles required 0", act);
    end
    start_req(2'h2, 13'h0005, 9'h100, 10'd3, 16'h00C0);
    capture(4, {2'h3, 13'h0AAA, 9'h055});
    n_chk++;
    if (nc_cmd.size() != 4) begin
      n_err++;
      $display("FAIL gate_cmd_count: %0d commands required 4", nc_cmd.size());
    end else if (nc_cmd[0] !== CMD_ACT || nc_bank[0] !== 2'h2 || nc_addr[0] !== 13'h0005 ||
                 nc_cmd[1] !== CMD_WR || nc_bank[1] !== 2'h2 || nc_addr[1] !== 13'h0100 ||
                 nc_cmd[2] !== CMD_BST || nc_cmd[3] !== CMD_PRE || nc_bank[3] !== 2'h2 ||
                 nc_addr[3] !== 13'h0000) begin
      n_err++;
      $display("FAIL gate_cmds: act=%h/%h wr=%h/%h pre=%h/%h required 2/0005 2/0100 2/0000",
               nc_bank[0], nc_addr[0], nc_bank[1], nc_addr[1], nc_bank[3], nc_addr[3]);
    end
    n_chk++;
    if (n_ack_c != 3 || n_end_c != 1 || q_busy[q_busy.size()-1] !== 1'b0) begin
      n_err++;
      $display("FAIL gate_counts: acks=%0d ends=%0d final_busy=%b required 3/1/0",
               n_ack_c, n_end_c, q_busy[q_busy.size()-1]);
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    start_req(2'h1, 13'h0123, 9'h010, 10'd4, 16'h00A0);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge wr_clk);
      if (i == 0) wr_en = 1'b0;
      if (wr_sdram_en) hit = 1;
    end
    n_chk++;
    if (!hit) begin
      n_err++;
      $display("FAIL rstmid_reach_data: data phase seen=%0d required 1", hit);
    end
    #2 wr_rst = 1'b1;
    #1;
    n_chk++;
    if (wr_sdram_cmd !== CMD_NOP || wr_sdram_bank !== 2'h3 || wr_sdram_addr !== 13'h1FFF ||
        wr_sdram_en !== 1'b0 || wr_sdram_data !== 16'h0) begin
      n_err++;
      $display("FAIL rstmid_async_bus: cmd=%b bank=%h addr=%h en=%b data=%h required 0111/3/1fff/0/0000",
               wr_sdram_cmd, wr_sdram_bank, wr_sdram_addr, wr_sdram_en, wr_sdram_data);
    end
    n_chk++;
    if (wr_ack !== 1'b0 || wr_busy !== 1'b0 || wr_end !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_async_flags: ack=%b busy=%b end=%b required 0/0/0", wr_ack, wr_busy, wr_end);
    end
    repeat (2) @(negedge wr_clk);
    wr_rst = 1'b0;
    start_req(2'h1, 13'h0123, 9'h010, 10'd4, 16'h00A0);
    capture(-1, '0);
    n_chk++;
    if (nc_cmd.size() != 4 || nc_cmd[0] !== CMD_ACT || nc_addr[0] !== 13'h0123 ||
        nc_cmd[1] !== CMD_WR || nc_addr[1] !== 13'h0010 || nc_cmd[2] !== CMD_BST ||
        nc_cmd[3] !== CMD_PRE) begin
      n_err++;
      $display("FAIL rstmid_rerun_cmds: %0d commands, first=%b/%h required 4, ACT/0123",
               nc_cmd.size(), nc_cmd[0], nc_addr[0]);
    end
    n_chk++;
    if (dq.size() != 4 || dq[0] !== 16'h00A0 || dq[3] !== 16'h00A3 || n_ack_c != 4 || n_end_c != 1) begin
      n_err++;
      $display("FAIL rstmid_rerun_data: words=%0d acks=%0d ends=%0d required 4 (A0..A3)/4/1",
               dq.size(), n_ack_c, n_end_c);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_page_split();
    test_carry();
    test_len0();
    test_gating();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
